// File: rtl/nibble_serial_sub.sv
// Multi-cycle W-bit subtractor F = X - Y - B0.
// One 4-bit carry-lookahead slice computes X + ~Y + carry, one nibble per
// cycle (LSB nibble first); the carry between nibbles is held in a register.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; results from the last completed op held
// RUN   | one nibble per edge; completion on the last nibble
module nibble_serial_sub #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] X,
   input  logic [4*NIBBLES-1:0] Y,
   input  logic                 B0,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] F,
   output logic                 B_out,
   output logic                 V,
   output logic                 Z
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [W-1:0]    x_q;
   logic [W-1:0]    y_q;
   logic [W-1:0]    res_q;
   logic            carry;
   logic [IW-1:0]   idx;

   logic [3:0]      a;
   logic [3:0]      b;
   logic [3:0]      g;
   logic [3:0]      p;
   logic [4:0]      c;
   logic [3:0]      sum;
   logic [W-1:0]    res_next;
   logic            last;

   // Lookahead slice on the current nibble; res_next is the result with it merged in
   always_comb begin
      a    = x_q[4*idx +: 4];
      b    = ~y_q[4*idx +: 4];
      g    = a & b;
      p    = a ^ b;
      c[0] = carry;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
      res_next = res_q;
      res_next[4*idx +: 4] = sum;
      last = (idx == IW'(NIBBLES - 1));
   end

   // Sequencer: operand capture, per-nibble accumulation, registered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         x_q   <= '0;
         y_q   <= '0;
         res_q <= '0;
         carry <= 1'b0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         F     <= '0;
         B_out <= 1'b0;
         V     <= 1'b0;
         Z     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  x_q   <= X;
                  y_q   <= Y;
                  carry <= ~B0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               res_q <= res_next;
               carry <= c[4];
               if (last) begin
                  // F is published whole, never nibble by nibble
                  idx   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  F     <= res_next;
                  B_out <= ~c[4];
                  Z     <= (res_next == '0);
                  V     <= (x_q[W-1] != y_q[W-1]) && (res_next[W-1] != x_q[W-1]);
                  state <= IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Bench for nibble_serial_sub (NIBBLES=4): directed vector table, handshake
// corner sequences and randomized operations against an arithmetic model.
module tb_nibble_serial_sub;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         B0;
   logic         busy;
   logic         done;
   logic [W-1:0] F;
   logic         B_out;
   logic         V;
   logic         Z;

   int pass_cnt = 0;
   int total    = 0;

   nibble_serial_sub #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y), .B0(B0),
      .busy(busy), .done(done), .F(F), .B_out(B_out), .V(V), .Z(Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        b0;
      logic [15:0] f;
      logic        bo;
      logic        v;
      logic        z;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: plain integer arithmetic on the operands
   task automatic model(input logic [15:0] x, input logic [15:0] y, input logic b0,
                        output logic [15:0] f, output logic bo, output logic v,
                        output logic z);
      int d;
      int sd;
      d  = int'(x) - int'(y) - int'(b0);
      sd = int'($signed(x)) - int'($signed(y)) - int'(b0);
      f  = d[15:0];
      bo = (d < 0);
      v  = (sd < -32768) || (sd > 32767);
      z  = (f == 16'h0000);
   endtask

   // Launch one op; returns cycles from accepting edge to done and busy-high samples
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic b0,
                         output int lat, output int bcnt);
      @(negedge clk);
      X = x; Y = y; B0 = b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      X = ~x; Y = ~y; B0 = ~b0;
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
      end
   endtask

   task automatic check_result(input string name, input logic [15:0] x,
                               input logic [15:0] y, input logic b0);
      logic [15:0] ef;
      logic eb, ev, ez;
      model(x, y, b0, ef, eb, ev, ez);
      check({name, ".F"}, F, ef);
      check({name, ".B_out"}, B_out, eb);
      check({name, ".V"}, V, ev);
      check({name, ".Z"}, Z, ez);
   endtask

   initial begin
      int lat, bcnt, gap;
      logic [15:0] rx, ry;
      logic        rb;

      vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; B0 = 1'b0;
      #12;
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.F", F, 0);
      check("reset.flags", {B_out, V, Z}, 0);
      @(negedge clk); rst_n = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].x, vecs[i].y, vecs[i].b0, lat, bcnt);
         check($sformatf("vec%0d.latency", i), lat, NIB);
         check($sformatf("vec%0d.busy_cycles", i), bcnt, NIB);
         check($sformatf("vec%0d.F", i), F, vecs[i].f);
         check($sformatf("vec%0d.B_out", i), B_out, vecs[i].bo);
         check($sformatf("vec%0d.V", i), V, vecs[i].v);
         check($sformatf("vec%0d.Z", i), Z, vecs[i].z);
         @(posedge clk); #1;
         check($sformatf("vec%0d.done_one_cycle", i), done, 0);
         check($sformatf("vec%0d.F_held", i), F, vecs[i].f);
      end

      // start pulsed mid-RUN is ignored
      @(negedge clk);
      X = 16'h4321; Y = 16'h0123; B0 = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      X = 16'h0000; Y = 16'hFFFF; B0 = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
      check("ignore.latency", lat, NIB);
      check_result("ignore", 16'h4321, 16'h0123, 1'b0);
      @(posedge clk); #1;
      check("ignore.no_second_done", done, 0);
      check("ignore.idle", busy, 0);

      // start during the done cycle is accepted
      run_op(16'h00F0, 16'h000F, 1'b0, lat, bcnt);
      X = 16'hABCD; Y = 16'h0BCD; B0 = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("donestart.done_falls", done, 0);
      check("donestart.busy", busy, 1);
      check("donestart.F_held", F, 16'h00E1);
      lat = 0;
      while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
      check("donestart.latency", lat, NIB);
      check_result("donestart", 16'hABCD, 16'h0BCD, 1'b1);

      // start held high: done every NIB+1 cycles
      @(negedge clk);
      X = 16'h0100; Y = 16'h0001; B0 = 1'b0; start = 1'b1;
      lat = 0;
      while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
      gap = 0;
      @(posedge clk); #1;
      while (!done && gap < 20) begin @(posedge clk); #1; gap++; end
      check("b2b.interval", gap + 1, NIB + 1);
      check_result("b2b", 16'h0100, 16'h0001, 1'b0);
      @(negedge clk); start = 1'b0;
      repeat (NIB + 2) @(posedge clk);

      // Reset mid-RUN
      @(negedge clk);
      X = 16'h5555; Y = 16'h1111; B0 = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b0; #1;
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.F", F, 0);
      check("abort.flags", {B_out, V, Z}, 0);
      bcnt = 0;
      repeat (NIB + 1) begin @(posedge clk); #1; if (done) bcnt++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; if (done) bcnt++; end
      check("abort.no_done", bcnt, 0);
      run_op(16'h9ABC, 16'h1234, 1'b1, lat, bcnt);
      check("after_abort.latency", lat, NIB);
      check_result("after_abort", 16'h9ABC, 16'h1234, 1'b1);

      // Randomized ops
      for (int n = 0; n < 40; n++) begin
         rx = 16'($urandom);
         ry = (n % 5 == 0) ? rx : 16'($urandom);
         rb = 1'($urandom);
         run_op(rx, ry, rb, lat, bcnt);
         check($sformatf("rand%0d.latency", n), lat, NIB);
         check_result($sformatf("rand%0d", n), rx, ry, rb);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle W-bit subtractor F = X − Y − B0, built from one 4-bit carry-lookahead slice reused once per nibble. Each nibble is computed as X + ~Y + carry.
- The borrow is registered between nibbles, LSB nibble first.
- This is the inverse-direction companion to the team's 4-bit CLA adder. It serves datapaths that need wide subtraction or compare without a full-width ripple chain.
- Start/busy/done handshake; results are held stable until the next start.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- X  input  W  minuend; captured on the accepting edge.
- Y  input  W  subtrahend; captured on the accepting edge.
- B0  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while the operation is in progress (RUN).
- done  output  1  one-cycle pulse when F/B_out/V/Z become valid.
- F  output  W  difference, X − Y − B0 mod 2^W.
- B_out  output  1  borrow-out; 1 iff X < Y + B0 (unsigned).
- V  output  1  signed overflow of the two's-complement subtraction.
- Z  output  1  1 iff F == 0.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, nibble index 0, internal X/Y/result registers 0.
  - Outputs busy=0, done=0, F=0, B_out=0, V=0, Z=0 immediately.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Latch X, Y and carry=~B0; index=0; go to RUN.
  - busy=1 from edge k; done=0.
- RUN, each edge:
  - nibble i = X[4i+3:4i] + ~Y[4i+3:4i] + carry, using lookahead generate/propagate within the slice.
  - Store the sum nibble in the internal result register; carry ← nibble carry-out; i ← i+1.
- Last nibble stored at edge k+NIBBLES:
  - State → IDLE, busy=0, done=1 for exactly one cycle.
  - F ← full result; B_out ← ~final carry; Z ← (result==0).
  - V ← (X[W-1] != Y[W-1]) && (result[W-1] != X[W-1]), using latched operands.
- Latency: done is high in the cycle after edge k+NIBBLES, i.e. NIBBLES cycles after the accepting edge.
- F, B_out, V and Z change only at the completion edge and hold until the next completion. F is never partially updated.
- start while busy=1: ignored and not queued. X/Y/B0 changes during RUN have no effect.
- start=1 during the done cycle: accepted (state is IDLE). The next op begins and done falls at that edge.
- start held high continuously: back-to-back ops, one every NIBBLES+1 cycles.
- Reset mid-RUN: aborts immediately. No done pulse; outputs go to 0.
- The carry chain between nibbles goes only through the registered carry. There is no combinational path from X/Y to the outputs.

Test Plan:
- Reset, then X=0x0005, Y=0x0003, B0=0, start → done 4 cycles after the accepting edge; F=0x0002, B_out=0, V=0, Z=0; busy high exactly 4 cycles.
- X=0x1000, Y=0x0001, B0=0 (borrow across three nibbles) → F=0x0FFF, B_out=0, V=0, Z=0.
- X=0x0000, Y=0x0001, B0=0 → F=0xFFFF, B_out=1, V=0. Then X=0x8000, Y=0x0001 → F=0x7FFF, B_out=0, V=1.
- X=0x1234, Y=0x1234, B0=0 → F=0x0000, Z=1, B_out=0. Repeat with B0=1 → F=0xFFFF, B_out=1, Z=0, V=0.
- Pulse start again 2 cycles into RUN with different operands → ignored; result matches the first op. Start during the done cycle → second op accepted, done again after 4 more cycles.
- Deassert rst_n at RUN cycle 2 → busy/done/F/B_out/V/Z all 0 asynchronously, no done pulse. A new op after release computes correctly.
